// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants,
// used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;
    localparam int S_W        = 5;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is
// chosen so that an idle line does not look like activity after reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receiver driven by a 16x oversample strobe: validates the start bit at
// its centre, shifts data in LSB-first, and flags frames with a low stop bit.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    localparam int               N_W         = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [N_W-1:0]   N_LAST      = N_W'(DBIT - 1);
    localparam logic [S_W-1:0]   S_MID       = S_W'(MID_TICK);
    localparam logic [S_W-1:0]   S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0]   S_STOP_LAST = S_W'(SB_TICK - 1);

    logic            w_rx_s;
    uart_state_t     r_state;
    logic [S_W-1:0]  r_s;
    logic [N_W-1:0]  r_n;
    logic [DBIT-1:0] r_shreg;
    logic [DBIT-1:0] r_dout;
    logic            r_done;
    logic            r_ferr;
    logic            r_armed;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_rx_sync (
        .clk  (clk),
        .reset(reset),
        .i_d  (rx),
        .o_q  (w_rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_shreg <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
            r_armed <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // Disarmed after a low stop sample so a held-low break yields one frame only
                IDLE: begin
                    if (w_rx_s) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_state <= START;
                        r_s     <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (r_s == S_MID) begin
                            if (!w_rx_s) begin
                                r_state <= DATA;
                                r_s     <= '0;
                                r_n     <= '0;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_s <= r_s + S_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (r_s == S_BIT_LAST) begin
                            r_s     <= '0;
                            r_shreg <= {w_rx_s, r_shreg[DBIT-1:1]};
                            if (r_n == N_LAST) begin
                                r_state <= STOP;
                            end else begin
                                r_n <= r_n + N_W'(1);
                            end
                        end else begin
                            r_s <= r_s + S_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (r_s == S_STOP_LAST) begin
                            r_dout  <= r_shreg;
                            r_ferr  <= ~w_rx_s;
                            r_done  <= 1'b1;
                            r_armed <= w_rx_s;
                            r_state <= IDLE;
                        end else begin
                            r_s <= r_s + S_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rx_dout      = r_dout;
    assign rx_done_tick = r_done;
    assign frame_err    = r_ferr;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for the oversampled UART receiver: an 8N1 instance and a
// 7-bit / 2-stop-bit instance share clock, reset and the oversample strobe.
module tb_uart_rx_oversampled;

    typedef struct {
        logic [8:0] data;
        logic       ferr;
        longint     tick;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx8;
    logic       rx7;
    logic       s_tick;
    logic       stall = 1'b0;
    logic [7:0] dout8;
    logic [6:0] dout7;
    logic       done8, done7, ferr8, ferr7;

    int     checks = 0;
    int     errors = 0;
    longint tick_cnt = 0;
    int     tdiv = 0;
    exp_t   q8[$];
    exp_t   q7[$];
    exp_t   e8, e7;
    logic [8:0] last8 = '0;
    logic [8:0] last7 = '0;
    logic       lastf8 = 1'b0;

    uart_rx_oversampled #(.DBIT(8), .SB_TICK(16)) dut8 (
        .clk(clk), .reset(reset), .rx(rx8), .s_tick(s_tick),
        .rx_dout(dout8), .rx_done_tick(done8), .frame_err(ferr8)
    );

    uart_rx_oversampled #(.DBIT(7), .SB_TICK(32)) dut7 (
        .clk(clk), .reset(reset), .rx(rx7), .s_tick(s_tick),
        .rx_dout(dout7), .rx_done_tick(done7), .frame_err(ferr7)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_tick) tick_cnt <= tick_cnt + 1;
    end

    // Oversample strobe: one clk in four, frozen while stall is set
    initial begin
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!stall) tdiv = (tdiv + 1) % 4;
            s_tick = !stall && (tdiv == 0);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (s_tick !== 1'b1);
        end
        #1;
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) rx7 = v;
        else     rx8 = v;
    endtask

    // Each line bit lasts 16 strobes; the start bit centre is 8 strobes in,
    // so the stop sample lands 8 + 16*nbits + sb_tick strobes after the edge.
    task automatic send_frame(input bit sel, input logic [8:0] data, input int nbits,
                              input logic stop_lvl, input int stop_ticks,
                              input int sb_tick, input int stall_bit);
        exp_t e;
        e.data = data & ((9'd1 << nbits) - 9'd1);
        e.ferr = ~stop_lvl;
        e.tick = tick_cnt + 8 + 16 * nbits + sb_tick;
        if (sel) q7.push_back(e);
        else     q8.push_back(e);
        set_rx(sel, 1'b0);
        wait_ticks(16);
        for (int k = 0; k < nbits; k++) begin
            set_rx(sel, data[k]);
            if (k == stall_bit) begin
                stall = 1'b1;
                repeat (100) @(posedge clk);
                #1;
                stall = 1'b0;
            end
            wait_ticks(16);
        end
        set_rx(sel, stop_lvl);
        wait_ticks(stop_ticks);
    endtask

    task automatic drain(input int max_clk);
        for (int i = 0; i < max_clk && (q8.size() != 0 || q7.size() != 0); i++)
            @(posedge clk);
        #1;
        chk("drain8", q8.size(), 0);
        chk("drain7", q7.size(), 0);
    endtask

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pulse8: got unexpected pulse rx_dout=%0h expected none", dout8);
            end else begin
                e8 = q8.pop_front();
                chk("dout8", dout8, e8.data);
                chk("ferr8", ferr8, e8.ferr);
                chk("tick8", tick_cnt, e8.tick);
                last8  = e8.data;
                lastf8 = e8.ferr;
            end
        end
    end

    always @(negedge clk) begin
        if (done7) begin
            if (q7.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pulse7: got unexpected pulse rx_dout=%0h expected none", dout7);
            end else begin
                e7 = q7.pop_front();
                chk("dout7", dout7, e7.data);
                chk("ferr7", ferr7, e7.ferr);
                chk("tick7", tick_cnt, e7.tick);
                last7 = e7.data;
            end
        end
    end

    initial begin
        logic [7:0] b;
        bit         bad;
        int         gap;

        reset = 1'b1;
        rx8   = 1'b1;
        rx7   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout8", dout8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_ferr8", ferr8, 0);
        chk("rst_dout7", dout7, 0);
        chk("rst_done7", done7, 0);
        chk("rst_ferr7", ferr7, 0);
        reset = 1'b0;
        wait_ticks(4);

        send_frame(0, 9'hA5, 8, 1'b1, 16, 16, -1);
        wait_ticks(16);

        send_frame(0, 9'h00, 8, 1'b1, 16, 16, -1);
        send_frame(0, 9'hFF, 8, 1'b1, 16, 16, -1);
        send_frame(0, 9'h3C, 8, 1'b1, 16, 16, -1);
        wait_ticks(16);

        set_rx(0, 1'b0);
        wait_ticks(5);
        set_rx(0, 1'b1);
        wait_ticks(40);
        chk("glitch_dout", dout8, last8);
        chk("glitch_ferr", ferr8, lastf8);

        send_frame(0, 9'h55, 8, 1'b0, 16, 16, -1);
        wait_ticks(30 * 16);
        chk("break_dout", dout8, 8'h55);
        chk("break_ferr", ferr8, 1);
        set_rx(0, 1'b1);
        wait_ticks(16);
        send_frame(0, 9'h12, 8, 1'b1, 16, 16, -1);
        wait_ticks(16);

        for (int i = 0; i < 20; i++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            gap = $urandom_range(0, 2);
            send_frame(0, {1'b0, b}, 8, !bad, 16, 16, -1);
            if (bad || gap != 0) begin
                set_rx(0, 1'b1);
                wait_ticks(16 * ((gap != 0) ? gap : 1));
            end
        end
        wait_ticks(16);
        drain(400);

        send_frame(1, 9'h5A, 7, 1'b1, 32, 32, -1);
        wait_ticks(16);
        send_frame(1, 9'h5A, 7, 1'b1, 32, 32, 3);
        wait_ticks(16);
        drain(400);
        chk("p7_dout", dout7, last7);

        send_frame(0, 9'hC3, 8, 1'b1, 16, 16, -1);
        wait_ticks(8);
        drain(400);
        set_rx(0, 1'b0);
        wait_ticks(16);
        for (int k = 0; k < 4; k++) begin
            set_rx(0, k[0]);
            wait_ticks(16);
        end
        set_rx(0, 1'b1);
        wait_ticks(4);
        reset = 1'b1;
        #1;
        chk("mid_rst_dout8", dout8, 0);
        chk("mid_rst_ferr8", ferr8, 0);
        chk("mid_rst_done8", done8, 0);
        chk("mid_rst_dout7", dout7, 0);
        last8  = '0;
        lastf8 = 1'b0;
        last7  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        rx8   = 1'b1;
        wait_ticks(32);
        send_frame(0, 9'h81, 8, 1'b1, 16, 16, -1);
        wait_ticks(16);
        drain(400);
        chk("final_dout8", dout8, 8'h81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
